// File: rtl/pdm_pkg.sv
// Shared constants for the PDM modulator / demodulator pair.
// Both ends take their sample width from here so loopback scales agree.
package pdm_pkg;

  localparam int unsigned DEF_DECIM      = 32;
  localparam int unsigned DEF_OUT_WIDTH  = 10;
  localparam int unsigned LOG2_DECIM     = $clog2(DEF_DECIM);
  localparam int unsigned ACC_W          = DEF_OUT_WIDTH + 1;
  localparam int unsigned PDM_DIN_WIDTH  = DEF_OUT_WIDTH;

  // Warm-up tracking: two decimation events prime the comb delays.
  typedef enum logic [1:0] {
    ST_WARM0 = 2'd0,
    ST_WARM1 = 2'd1,
    ST_RUN   = 2'd2
  } warm_state_e;

endpackage

// File: rtl/pdm_demod_cic_int.sv
// CIC integrator stage: enabled wrap-around accumulator with synchronous
// active-low clear; exposes the value it takes on the current cycle.
module cic_int
  import pdm_pkg::*;
#(
  parameter int unsigned W = ACC_W
) (
  input  logic         clk,
  input  logic         i_clr_n,
  input  logic         i_en,
  input  logic [W-1:0] i_add,
  output logic [W-1:0] o_acc_next_c
);

  logic [W-1:0] r_acc;
  logic [W-1:0] w_next;

  // Modulo-2^W wrap is intentional; the comb stages undo it.
  assign w_next       = i_en ? (r_acc + i_add) : r_acc;
  assign o_acc_next_c = w_next;

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_next;
    end
  end

endmodule

// File: rtl/pdm_demod.sv
// 2nd-order CIC (sinc^2) PDM demodulator: 1-bit unipolar stream in,
// OUT_WIDTH-bit unsigned samples out every DECIM accepted bits.
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int unsigned DECIM     = DEF_DECIM,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pdm_in,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 out_valid,
  output logic                 settled
);

  localparam int unsigned PH_W = $clog2(DECIM);
  localparam int unsigned AW   = OUT_WIDTH + 1;
  localparam logic [AW-1:0]   FULL_SCALE = AW'(1) << OUT_WIDTH;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DECIM - 1);

  if ((OUT_WIDTH != 2 * PH_W) || (DECIM < 4) || (DECIM > 256) ||
      ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_cfg
    $fatal(1, "pdm_demod: DECIM must be a power of two in 4..256 and OUT_WIDTH = 2*log2(DECIM)");
  end

  logic [PH_W-1:0]      r_phase;
  logic [AW-1:0]        w_int1_next;
  logic [AW-1:0]        w_int2_next;
  logic [AW-1:0]        r_d1;
  logic [AW-1:0]        r_d2;
  logic [AW-1:0]        w_c1;
  logic [AW-1:0]        w_c2;
  logic [OUT_WIDTH-1:0] w_result;
  logic                 w_event;
  logic                 w_emit;
  warm_state_e          r_state;
  warm_state_e          w_state_next;
  logic [OUT_WIDTH-1:0] r_dout;
  logic                 r_valid;
  logic                 r_settled;

  cic_int #(.W(AW)) u_int1 (
    .clk          (clk),
    .i_clr_n      (rst),
    .i_en         (en),
    .i_add        (AW'(pdm_in)),
    .o_acc_next_c (w_int1_next)
  );

  cic_int #(.W(AW)) u_int2 (
    .clk          (clk),
    .i_clr_n      (rst),
    .i_en         (en),
    .i_add        (w_int1_next),
    .o_acc_next_c (w_int2_next)
  );

  // Comb stages run at the decimated rate off the integrator's next value.
  assign w_event  = en && (r_phase == LAST_PHASE);
  assign w_c1     = w_int2_next - r_d1;
  assign w_c2     = w_c1 - r_d2;
  assign w_result = (w_c2 >= FULL_SCALE) ? '1 : w_c2[OUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_WARM0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    if (w_event) begin
      unique case (r_state)
        ST_WARM0: w_state_next = ST_WARM1;
        ST_WARM1: w_state_next = ST_RUN;
        ST_RUN:   w_emit       = 1'b1;
        default:  w_state_next = ST_WARM0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase   <= '0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (en) begin
        r_phase <= r_phase + PH_W'(1);
      end
      if (w_event) begin
        r_d1 <= w_int2_next;
        r_d2 <= w_c1;
      end
      if (w_emit) begin
        r_dout    <= w_result;
        r_settled <= 1'b1;
      end
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_valid;
  assign settled   = r_settled;

endmodule

// File: tb/tb_pdm_demod.sv
// Scoreboard bench for pdm_demod: a direct triangular-FIR reference model
// predicts every decimated sample and the cycle it must appear on.
module tb_pdm_demod;

  localparam int D    = 32;
  localparam int OW   = 10;
  localparam int OMAX = (1 << OW) - 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          pdm_in = 1'b0;
  logic [OW-1:0] dout;
  logic          out_valid;
  logic          settled;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hold_exp = 0;
  int   ev = 0;
  int   mod_acc = 0;
  int   hist[$];
  exp_t q[$];

  pdm_demod #(.DECIM(D), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pdm_in    (pdm_in),
    .dout      (dout),
    .out_valid (out_valid),
    .settled   (settled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Sinc^2 = triangular FIR 1,2..D..2,1 over accepted bits, capped to OMAX.
  function automatic int fir();
    int n = hist.size() - 1;
    int s = 0;
    for (int j = 0; j <= 2 * D - 2; j++) begin
      if (n - j >= 0) s += hist[n - j] * ((j < D) ? (j + 1) : (2 * D - 1 - j));
    end
    return (s > OMAX) ? OMAX : s;
  endfunction

  // First-order sigma-delta modulator standing in for the transmit side.
  function automatic logic mod_bit(input int din);
    mod_acc += din;
    if (mod_acc >= (1 << OW)) begin
      mod_acc -= (1 << OW);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step(input logic e, input logic b);
    @(posedge clk);
    #1;
    en     = e;
    pdm_in = b;
    if (e) begin
      hist.push_back(int'(b));
      if (hist.size() % D == 0) begin
        ev++;
        if (ev >= 3) q.push_back('{val: fir(), cyc: cyc + 1});
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    en     = 1'b1;
    pdm_in = 1'($urandom);
    hist.delete();
    ev = 0;
    @(posedge clk);
    #1;
    hold_exp = 0;
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_settled", int'(settled), 0);
    rst = 1'b1;
    en  = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid at cycle %0d: got dout=%0d, expected no strobe", cyc, dout);
        end else begin
          e = q.pop_front();
          chk("dout", int'(dout), e.val);
          chk("valid_cycle", cyc, e.cyc);
          chk("settled_on_valid", int'(settled), 1);
          hold_exp = e.val;
        end
      end else begin
        chk("dout_hold", int'(dout), hold_exp);
      end
    end
  endtask

  initial begin
    int dins[4];
    int start;
    int diff;
    dins = '{300, 0, 511, 1023};

    fork
      monitor();
    join_none

    // All zeros: three strobes, settled only after the third event.
    do_reset();
    chk("settled_init", int'(settled), 0);
    repeat (2 * D) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("settled_warm", int'(settled), 0);
    repeat (3 * D) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("settled_after", int'(settled), 1);
    step(1'b0, 1'b0);

    // All ones: raw 1024 must saturate to 1023.
    do_reset();
    repeat (6 * D) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    chk("ones_sat", int'(dout), OMAX);

    // Alternating pattern, both starting phases.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      for (int i = 0; i < 6 * D; i++) step(1'b1, 1'((i + p) % 2));
      repeat (2) step(1'b0, 1'b0);
      chk("alt_half", int'(dout), 512);
    end

    // Modulator loopback at several densities.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      mod_acc = 0;
      repeat (6 * D) step(1'b1, mod_bit(dins[k]));
      repeat (2) step(1'b0, 1'b0);
      diff = int'(dout) - dins[k];
      if (diff < 0) diff = -diff;
      chk("mod_tol", int'(diff <= D), 1);
    end

    // Alternating stream with en randomly low about half the time.
    do_reset();
    start = int'($urandom_range(0, 1));
    for (int i = 0; i < 6 * D; i++) begin
      while ($urandom_range(0, 1) == 0) step(1'b0, 1'($urandom));
      step(1'b1, 1'((i + start) % 2));
    end
    repeat (2) step(1'b0, 1'b0);
    chk("gap_alt", int'(dout), 512);

    // Reset at phase 17 of the fourth block, then a fresh warm-up.
    do_reset();
    repeat (3 * D + 17) step(1'b1, 1'($urandom));
    do_reset();
    repeat (4 * D) step(1'b1, 1'($urandom));

    // Random bits with random enable gaps.
    do_reset();
    for (int i = 0; i < 8 * D; i++) step(1'($urandom_range(0, 3) != 0), 1'($urandom));

    repeat (4) step(1'b0, 1'b0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_demod.md
Name: pdm_demod

Overview:
- Receive-side counterpart of the 1-bit PDM modulator: converts a 1-bit pulse-density stream back into OUT_WIDTH-bit unsigned samples.
- Uses a 2nd-order CIC (sinc²) decimator with decimation DECIM.
- Used to loop back modulator outputs (sine and saw paths) for self-check, and to accept external PDM sources (e.g. microphones).
- Output scale matches the modulator's din: density d maps to approximately d·2^OUT_WIDTH.

Parameters:
- DECIM, 32, decimation ratio; power of two, 4..256.
- OUT_WIDTH, 10, output sample width; must equal 2·log2(DECIM) (elaboration-time check, fatal on mismatch).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (rst=0 resets on the clk rising edge).
- en  input  1  sample enable; pdm_in is consumed only on cycles with en=1.
- pdm_in  input  1  PDM bit; 1 adds +1 and 0 adds 0 (unipolar, same as the modulator).
- dout  output  OUT_WIDTH  decimated sample, unsigned.
- out_valid  output  1  one-cycle strobe; dout is new and valid.
- settled  output  1  high once the filter warm-up is complete; stays high until reset.

Behaviour:
- Reset (rst=0 at a clk edge): phase counter, both integrators, both comb delay registers, warm-up counter, dout, out_valid and settled all cleared to 0. Reset overrides en. Reset mid-block discards the partial block; the warm-up restarts.
- Accumulator width ACC_W = OUT_WIDTH+1 (11 bits default). Integrators wrap modulo 2^ACC_W; this is intentional and correct for CIC. No saturation inside the integrators.
- On each en=1 cycle:
  - int1 <= int1 + pdm_in
  - int2 <= int2 + int1_next, where int1_next is the value int1 takes on this cycle.
  - phase <= phase+1, wrapping at DECIM-1 -> 0.
- en=0: all state holds and out_valid=0.
- Decimation event: en=1 and phase==DECIM-1. Within that cycle, using int2_next:
  - c1 = int2_next - d1; d1 <= int2_next
  - c2 = c1 - d2; d2 <= c1
  - All of these are modulo 2^ACC_W.
- c2 range is 0..DECIM² (0..1024).
- Output mapping: result = (c2 >= 2^OUT_WIDTH) ? 2^OUT_WIDTH-1 : c2. The only saturating input is the all-ones stream; 1024 maps to 1023.
- Warm-up: a 2-bit counter counts decimation events, saturating at 2.
  - Events 1 and 2 update the comb delays only; dout does not change and out_valid stays 0.
  - From event 3 onward: dout <= result and out_valid=1 on the clock edge closing the event cycle, so out_valid is visible the cycle after the last contributing en cycle.
  - settled goes to 1 together with the first out_valid.
- Latency: 1 clk from the last contributing input bit to dout/out_valid. Filter group delay is DECIM-1 input samples.
- Throughput: at most one out_valid per DECIM en-cycles. out_valid is never high on two consecutive cycles unless DECIM en-cycles separate them (impossible for DECIM>=4).
- en toggled arbitrarily: only en=1 cycles count toward phase. Results are identical to a gap-free stream of the same bits.
- dout holds its value between strobes.

Decomposition:
- Shared package (pdm_pkg): DECIM and OUT_WIDTH defaults, plus localparams LOG2_DECIM=$clog2(DECIM) and ACC_W=OUT_WIDTH+1. The modulator's width constant is also moved here so both ends share it.
- One natural sub-module, cic_int: an ACC_W-bit enabled wrap-around accumulator with synchronous active-low clear. It exposes its next value and is instantiated twice. Comb, saturation and control stay inline.

Test Plan:
- Reset then 5·DECIM en-cycles of pdm_in=0 -> out_valid pulses 3 times, all with dout=0; settled rises on the first pulse (after event 3 at en-cycle 96, pulse at clk 97).
- Constant pdm_in=1 -> after warm-up dout=1023 on every strobe (the saturation path, raw 1024).
- Alternating 1,0 pattern -> dout=512 every strobe after settle; phase alignment must not affect this.
- Existing pdm modulator driven with din=300 feeding pdm_in, en=1 -> settled dout within 300±2 on every strobe. Repeat with din=0, 511, 1023 (1023 within ±2, capped at 1023).
- Same bitstream as scenario 3, but en randomly low 50% of cycles -> identical dout sequence; out_valid only when 32 en-cycles have completed.
- Assert rst=0 for 1 cycle at phase 17 of the 4th block -> next cycle all outputs 0. First out_valid comes 3·DECIM en-cycles later, and the value matches a fresh-reset run.
